// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-dependency scoreboard beside the decode stage.
// Tracks destination tags of in-flight instructions through DEPTH slots
// (slot 0 youngest), raises a decode stall on read-after-write hazards,
// drops the youngest FLUSH_DEPTH slots on a flush, and counts stalled cycles.
// Optional feature macro: HAZARD_SCOREBOARD_FORWARD_EN
//   defined   -> stall only on load-use, live one-hot bypass selects
//   undefined -> full interlock on any tracked match, bypass selects tied to 0
module hazard_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [DEPTH-1:0]  fwd_rs_sel,
  output logic [DEPTH-1:0]  fwd_rt_sel,
  output logic              busy,
  output logic [15:0]       stall_cnt
);

  logic [DEPTH-1:0]  slot_vld;
  logic [REG_AW-1:0] slot_tag [DEPTH];
  logic [DEPTH-1:0]  match_rs;
  logic [DEPTH-1:0]  match_rt;
  logic [DEPTH-1:0]  kill_mask;
  logic              hazard;
  logic              rec_vld;

  // Per-slot source match; register 0 is hardwired and never a hazard.
  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int s = 0; s < DEPTH; s++) begin
      match_rs[s] = id_rs_use & slot_vld[s] & (slot_tag[s] == id_rs) & (id_rs != '0);
      match_rt[s] = id_rt_use & slot_vld[s] & (slot_tag[s] == id_rt) & (id_rt != '0);
    end
  end

  // Slots killed by a flush, cleared before they shift one position older.
  always_comb begin
    kill_mask = '0;
    for (int s = 0; s < DEPTH; s++) begin
      kill_mask[s] = flush && (s < FLUSH_DEPTH);
    end
  end

`ifdef HAZARD_SCOREBOARD_FORWARD_EN

  logic [DEPTH-1:0] slot_ld;
  logic [DEPTH-1:0] elig_rs;
  logic [DEPTH-1:0] elig_rt;

  // Lowest-index (youngest) set bit as a one-hot vector.
  function automatic logic [DEPTH-1:0] youngest(input logic [DEPTH-1:0] m);
    logic [DEPTH-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if (m[s] && !found) begin
        sel[s] = 1'b1;
        found  = 1'b1;
      end
    end
    return sel;
  endfunction

  // Only a load still in slot 0 cannot be bypassed; everything older can.
  always_comb begin
    hazard  = (match_rs[0] | match_rt[0]) & slot_ld[0];
    elig_rs = match_rs;
    elig_rt = match_rt;
    elig_rs[0] = match_rs[0] & ~slot_ld[0];
    elig_rt[0] = match_rt[0] & ~slot_ld[0];
    fwd_rs_sel = youngest(elig_rs);
    fwd_rt_sel = youngest(elig_rt);
  end

  // Load flag travels with its slot so the bypass knows when data is ready.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      slot_ld <= '0;
    end else begin
      slot_ld[0] <= id_is_load;
      for (int i = 1; i < DEPTH; i++) begin
        slot_ld[i] <= slot_ld[i-1];
      end
    end
  end

`else

  logic unused_is_load;

  // Full interlock: any in-flight writer of a source holds decode.
  always_comb begin
    hazard         = |(match_rs | match_rt);
    fwd_rs_sel     = '0;
    fwd_rt_sel     = '0;
    unused_is_load = id_is_load;
  end

`endif

  // Stall and entry recording; a flush discards decode instead of holding it.
  always_comb begin
    stall   = id_valid & ~flush & hazard;
    rec_vld = id_valid & id_wr & (id_rd != '0) & ~stall & ~flush;
  end

  // Slot shift register: record at slot 0, age by one, oldest retires.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_tag[i] <= '0;
      end
    end else begin
      slot_vld[0] <= rec_vld;
      slot_tag[0] <= id_rd;
      for (int i = 1; i < DEPTH; i++) begin
        slot_vld[i] <= slot_vld[i-1] & ~kill_mask[i-1];
        slot_tag[i] <= slot_tag[i-1];
      end
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign busy = |slot_vld;

endmodule
